// File: rtl/enet_nios_lan_bus_arbiter.sv
// Two-port Avalon arbiter sequencing a 16-bit async chip-select/strobe LAN bus with round-robin grants.
// Optional ENET_ARB_TURNAROUND_EN inserts one dead bus cycle after every read.
module enet_nios_lan_bus_arbiter #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 16,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_waitrequest,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_waitrequest,
   output logic              enet_cs_n,
   output logic              enet_rd_n,
   output logic              enet_wr_n,
   output logic [ADDR_W-1:0] enet_addr,
   output logic [DATA_W-1:0] enet_data_out,
   output logic              enet_data_oe,
   input  logic [DATA_W-1:0] enet_data_in,
   output logic              busy
);

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3
`ifdef ENET_ARB_TURNAROUND_EN
      , TURN = 3'd4
`endif
   } state_t;

   state_t     state_reg;
   logic [3:0] cnt_reg;
   logic       grant_reg;
   logic       last_grant_reg;
   logic       wr_reg;

   logic              req0, req1, pick, pick_wr, last_done;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   // On a tie the port that did not win last time gets the bus.
   assign pick       = (req0 & req1) ? ~last_grant_reg : req1;
   assign pick_wr    = pick ? m1_write : m0_write;
   assign pick_addr  = pick ? m1_address : m0_address;
   assign pick_wdata = pick ? m1_writedata : m0_writedata;

   assign last_done      = (state_reg == HOLD) && (cnt_reg == 4'd0);
   assign m0_waitrequest = req0 & ~(last_done & ~grant_reg);
   assign m1_waitrequest = req1 & ~(last_done & grant_reg);
   assign busy           = (state_reg != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         wr_reg         <= 1'b0;
         enet_cs_n      <= 1'b1;
         enet_rd_n      <= 1'b1;
         enet_wr_n      <= 1'b1;
         enet_addr      <= '0;
         enet_data_out  <= '0;
         enet_data_oe   <= 1'b0;
         m0_readdata    <= '0;
         m1_readdata    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req0 | req1) begin
                  state_reg      <= SETUP;
                  cnt_reg        <= SETUP_LD;
                  grant_reg      <= pick;
                  last_grant_reg <= pick;
                  wr_reg         <= pick_wr;
                  enet_addr      <= pick_addr;
                  enet_cs_n      <= 1'b0;
                  enet_data_oe   <= pick_wr;
                  if (pick_wr) enet_data_out <= pick_wdata;
               end
            end
            SETUP: begin
               if (cnt_reg == 4'd0) begin
                  state_reg <= STROBE;
                  cnt_reg   <= STROBE_LD;
                  enet_wr_n <= ~wr_reg;
                  enet_rd_n <= wr_reg;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            STROBE: begin
               if (cnt_reg == 4'd0) begin
                  state_reg <= HOLD;
                  cnt_reg   <= HOLD_LD;
                  enet_wr_n <= 1'b1;
                  enet_rd_n <= 1'b1;
                  // Chip drives valid data right up to the rising read strobe.
                  if (!wr_reg) begin
                     if (grant_reg) m1_readdata <= enet_data_in;
                     else           m0_readdata <= enet_data_in;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            HOLD: begin
               if (cnt_reg == 4'd0) begin
                  enet_cs_n    <= 1'b1;
                  enet_data_oe <= 1'b0;
`ifdef ENET_ARB_TURNAROUND_EN
                  state_reg    <= wr_reg ? IDLE : TURN;
`else
                  state_reg    <= IDLE;
`endif
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_enet_nios_lan_bus_arbiter.sv
// Directed scoreboard bench for enet_nios_lan_bus_arbiter: default timing instance plus a 2/5/2 instance.
module tb_enet_nios_lan_bus_arbiter;

`ifdef ENET_ARB_TURNAROUND_EN
   localparam int T = 1;
`else
   localparam int T = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  m0_address, m1_address;
   logic [15:0] m0_writedata, m1_writedata, enet_data_in;
   logic        sel;

   logic [15:0] a_m0_rd, a_m1_rd, a_dout, b_m0_rd, b_m1_rd, b_dout;
   logic        a_m0_wt, a_m1_wt, a_cs_n, a_rd_n, a_wr_n, a_oe, a_busy;
   logic        b_m0_wt, b_m1_wt, b_cs_n, b_rd_n, b_wr_n, b_oe, b_busy;
   logic [3:0]  a_addr, b_addr;

   logic [15:0] s_m0_rd, s_m1_rd, s_dout;
   logic        s_m0_wt, s_m1_wt, s_cs_n, s_rd_n, s_wr_n, s_oe, s_busy;
   logic [3:0]  s_addr;

   always #5 clk = ~clk;

   enet_nios_lan_bus_arbiter dut_a (
      .clk(clk), .reset_n(reset_n),
      .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
      .m0_readdata(a_m0_rd), .m0_waitrequest(a_m0_wt),
      .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
      .m1_readdata(a_m1_rd), .m1_waitrequest(a_m1_wt),
      .enet_cs_n(a_cs_n), .enet_rd_n(a_rd_n), .enet_wr_n(a_wr_n), .enet_addr(a_addr),
      .enet_data_out(a_dout), .enet_data_oe(a_oe), .enet_data_in(enet_data_in), .busy(a_busy)
   );

   enet_nios_lan_bus_arbiter #(.SETUP_CYC(2), .STROBE_CYC(5), .HOLD_CYC(2)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
      .m0_readdata(b_m0_rd), .m0_waitrequest(b_m0_wt),
      .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
      .m1_readdata(b_m1_rd), .m1_waitrequest(b_m1_wt),
      .enet_cs_n(b_cs_n), .enet_rd_n(b_rd_n), .enet_wr_n(b_wr_n), .enet_addr(b_addr),
      .enet_data_out(b_dout), .enet_data_oe(b_oe), .enet_data_in(enet_data_in), .busy(b_busy)
   );

   assign s_m0_rd = sel ? b_m0_rd : a_m0_rd;
   assign s_m1_rd = sel ? b_m1_rd : a_m1_rd;
   assign s_m0_wt = sel ? b_m0_wt : a_m0_wt;
   assign s_m1_wt = sel ? b_m1_wt : a_m1_wt;
   assign s_cs_n  = sel ? b_cs_n  : a_cs_n;
   assign s_rd_n  = sel ? b_rd_n  : a_rd_n;
   assign s_wr_n  = sel ? b_wr_n  : a_wr_n;
   assign s_addr  = sel ? b_addr  : a_addr;
   assign s_dout  = sel ? b_dout  : a_dout;
   assign s_oe    = sel ? b_oe    : a_oe;
   assign s_busy  = sel ? b_busy  : a_busy;

   typedef struct {
      int          port;
      bit          rd;
      logic [15:0] data;
      logic [3:0]  addr;
      int          when;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, t0 = 0;
   int   left0, left1;
   int   cs_lo, rd_lo, wr_lo, oe_hi, rd_first, wr_first;
   int   addr_bad, data_bad, oe_bad, idle_run, last_gap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int port, input bit rd, input logic [15:0] data,
                       input logic [3:0] addr, input int when);
      exp_t e;
      e.port = port; e.rd = rd; e.data = data; e.addr = addr; e.when = when;
      sb.push_back(e);
   endtask

   task automatic begin_test();
      t0 = cyc;
      cs_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0; rd_first = -1; wr_first = -1;
      addr_bad = 0; data_bad = 0; oe_bad = 0; idle_run = 0; last_gap = -1;
   endtask

   // Samples one cycle per iteration at the falling edge; pops the scoreboard on each completion.
   task automatic run(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         int   p;
         exp_t e;
         @(negedge clk);
         if (!s_cs_n) cs_lo++;
         if (!s_rd_n) begin rd_lo++; if (rd_first < 0) rd_first = cyc - t0; end
         if (!s_wr_n) begin wr_lo++; if (wr_first < 0) wr_first = cyc - t0; end
         if (s_oe) oe_hi++;
         if (s_oe && s_cs_n) oe_bad++;
         if (!s_cs_n && sb.size() > 0 && s_addr !== sb[0].addr) addr_bad++;
         if (s_oe && (sb.size() == 0 || sb[0].rd || s_dout !== sb[0].data)) data_bad++;
         if (s_cs_n) idle_run++;
         else begin
            if (idle_run > 0) last_gap = idle_run;
            idle_run = 0;
         end
         p = -1;
         if ((m0_read | m0_write) && !s_m0_wt) p = 0;
         if ((m1_read | m1_write) && !s_m1_wt) p = (p == 0) ? 2 : 1;
         if (p >= 0) begin
            if (sb.size() == 0) begin
               chk("unexpected_completion", p, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("grant_port", p, e.port);
               chk("done_cycle", cyc - t0, e.when);
               if (e.rd) chk("readdata", (p == 1) ? s_m1_rd : s_m0_rd, e.data);
            end
            if (p == 0 || p == 2) left0--;
            if (p == 1 || p == 2) left1--;
         end
         @(posedge clk); #1;
         if (left0 <= 0) begin m0_read = 0; m0_write = 0; end
         if (left1 <= 0) begin m1_read = 0; m1_write = 0; end
      end
      chk("all_done", sb.size(), 0);
   endtask

   initial begin
      reset_n = 0; sel = 0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_address = 0; m1_address = 0; m0_writedata = 0; m1_writedata = 0;
      enet_data_in = 0; left0 = 0; left1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs_n", a_cs_n, 1);
      chk("rst_rd_n", a_rd_n, 1);
      chk("rst_wr_n", a_wr_n, 1);
      chk("rst_addr", a_addr, 0);
      chk("rst_dout", a_dout, 0);
      chk("rst_oe", a_oe, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_m0_rd", a_m0_rd, 0);
      chk("rst_m1_rd", a_m1_rd, 0);
      chk("rst_m0_wt", a_m0_wt, 0);
      chk("rst_m1_wt", a_m1_wt, 0);
      reset_n = 1;

      // Reset in the middle of a write strobe
      @(posedge clk); #1;
      m0_write = 1; m0_address = 4'h5; m0_writedata = 16'h5555;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_wr_n", a_wr_n, 0);
      chk("mid_cs_n", a_cs_n, 0);
      chk("mid_oe", a_oe, 1);
      #2 reset_n = 0;
      #1;
      chk("abort_wr_n", a_wr_n, 1);
      chk("abort_cs_n", a_cs_n, 1);
      chk("abort_oe", a_oe, 0);
      chk("abort_busy", a_busy, 0);
      chk("abort_no_done", a_m0_wt, 1);

      // First tie after reset goes to port 0
      m0_write = 0; m0_read = 1; m0_address = 4'h3;
      m1_read = 1; m1_address = 4'h7; enet_data_in = 16'h0123;
      @(posedge clk); #1;
      reset_n = 1;
      begin_test();
      left0 = 1; left1 = 1;
      push(0, 1, 16'h0123, 4'h3, 5);
      push(1, 1, 16'h0123, 4'h7, 11 + T);
      run(14);

      // Single m0 read
      m0_read = 1; m0_address = 4'h3; enet_data_in = 16'hBEEF;
      begin_test(); left0 = 1;
      push(0, 1, 16'hBEEF, 4'h3, 5);
      run(8);
      chk("rd_cs_low", cs_lo, 5);
      chk("rd_strobe_len", rd_lo, 3);
      chk("rd_strobe_start", rd_first, 2);
      chk("rd_no_wr", wr_lo, 0);
      chk("rd_oe", oe_hi, 0);
      chk("rd_addr_stable", addr_bad, 0);

      // Single m1 write
      m1_write = 1; m1_address = 4'hA; m1_writedata = 16'h1234; enet_data_in = 16'hDEAD;
      begin_test(); left1 = 1;
      push(1, 0, 16'h1234, 4'hA, 5);
      run(8);
      chk("wr_cs_low", cs_lo, 5);
      chk("wr_strobe_len", wr_lo, 3);
      chk("wr_strobe_start", wr_first, 2);
      chk("wr_no_rd", rd_lo, 0);
      chk("wr_oe_window", oe_hi, 5);
      chk("wr_oe_in_cs", oe_bad, 0);
      chk("wr_addr", addr_bad, 0);
      chk("wr_data", data_bad, 0);
      chk("hold_m0_rd", a_m0_rd, 16'hBEEF);
      chk("hold_m1_rd", a_m1_rd, 16'h0123);

      // Both ports requesting continuously
      m0_read = 1; m0_address = 4'h1; enet_data_in = 16'h4321;
      m1_write = 1; m1_address = 4'h2; m1_writedata = 16'hA5A5;
      begin_test(); left0 = 2; left1 = 2;
      push(0, 1, 16'h4321, 4'h1, 5);
      push(1, 0, 16'hA5A5, 4'h2, 11 + T);
      push(0, 1, 16'h4321, 4'h1, 17 + T);
      push(1, 0, 16'hA5A5, 4'h2, 23 + 2 * T);
      run(28);
      chk("rr_addr", addr_bad, 0);
      chk("rr_data", data_bad, 0);
      chk("rr_oe_in_cs", oe_bad, 0);

      // Read then write: gap between HOLD and next SETUP
      m0_read = 1; m0_address = 4'h4; enet_data_in = 16'h0F0F;
      m1_write = 1; m1_address = 4'h9; m1_writedata = 16'h3C3C;
      begin_test(); left0 = 1; left1 = 1;
      push(0, 1, 16'h0F0F, 4'h4, 5);
      push(1, 0, 16'h3C3C, 4'h9, 11 + T);
      run(14);
      chk("turn_gap", last_gap, 1 + T);
      chk("turn_oe_in_cs", oe_bad, 0);

      // Stretched timing instance
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1; sel = 1;
      m0_read = 1; m0_address = 4'h6; enet_data_in = 16'h7E57;
      begin_test(); left0 = 1;
      push(0, 1, 16'h7E57, 4'h6, 9);
      run(12);
      chk("long_cs_low", cs_lo, 9);
      chk("long_strobe_len", rd_lo, 5);
      chk("long_strobe_start", rd_first, 3);
      chk("long_addr", addr_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/enet_nios_lan_bus_arbiter.md
# enet_nios_lan_bus_arbiter

Sequences and shares the external Ethernet-controller bus (16-bit async chip-select/strobe interface) between two Avalon slave ports: port 0 (Nios data master) and port 1 (Ethernet DMA). Round-robin arbitration; programmable setup/strobe/hold wait states; registered external strobes. Sits between the system interconnect and the board-level LAN chip pins in the enet_nios PLD.

## Interface
- ADDR_W, 4, external address width
- DATA_W, 16, data width
- SETUP_CYC, 1, cycles of address/CS before strobe (1..15)
- STROBE_CYC, 3, cycles rd_n/wr_n low (1..15)
- HOLD_CYC, 1, cycles after strobe with CS held (1..15)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_read, m0_write  in  1  port 0 request (held until waitrequest low)
- m0_address  in  ADDR_W  port 0 address
- m0_writedata  in  DATA_W  port 0 write data
- m0_readdata  out  DATA_W  port 0 read data, valid when m0_waitrequest low
- m0_waitrequest  out  1  port 0 stall
- m1_* (read, write, address, writedata, readdata, waitrequest): identical set for port 1
- enet_cs_n, enet_rd_n, enet_wr_n  out  1  external strobes, active low, registered
- enet_addr  out  ADDR_W  external address, registered
- enet_data_out  out  DATA_W  write data driven to pad
- enet_data_oe  out  1  pad output enable
- enet_data_in  in  DATA_W  pad read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN (TURN only with macro). A 4-bit down-counter times SETUP/STROBE/HOLD.
- IDLE: request = read|write. One requester -> grant it. Both -> grant port != last_grant. None -> stay. Grant, last_grant, address, data, direction latched on IDLE->SETUP.
- read and write both high on one port: treated as write.
- SETUP: cs_n=0, addr driven, rd_n=wr_n=1; writes: data_oe=1, data_out driven.
- STROBE: rd_n=0 (read) or wr_n=0 (write). Read data captured from enet_data_in on the edge leaving STROBE into the granted port's readdata register.
- HOLD: strobes high, cs_n=0, write data/oe held. Last HOLD cycle: granted port's waitrequest=0 (completion cycle). Then -> IDLE, or -> TURN if macro on and access was a read.
- waitrequest = (read|write) & ~completion; non-requesting port sees waitrequest low only when idle-requestless (no request -> don't-care, driven 0).
- readdata of a port holds its value until its next read completes.
- Reset values: cs_n=rd_n=wr_n=1, enet_addr=0, data_out=0, data_oe=0, readdata=0 both ports, busy=0, state IDLE, last_grant=1 (port 0 wins first tie). Reset mid-access aborts immediately; no completion issued.
- Request withdrawn mid-access (protocol violation): access still runs to completion; completion cycle discarded.

## Timing
- Request asserted in IDLE cycle 0 -> waitrequest low in cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC-1 = SETUP+STROBE+HOLD (defaults: cycle 5).
- Back-to-back: next access enters SETUP no earlier than 1 cycle after completion cycle (IDLE always visited once); plus 1 TURN cycle after reads when macro on.
- Strobe low width exactly STROBE_CYC cycles; CS low exactly SETUP+STROBE+HOLD cycles; address stable over entire CS-low window.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1...

## Configuration
- ENET_ARB_TURNAROUND_EN defined: after every read, one TURN cycle (cs_n=1, all strobes high, data_oe=0) before IDLE, guaranteeing a dead bus cycle before the chip stops driving. Undefined: HOLD -> IDLE directly; TURN state absent.

## Test plan
- Reset mid-STROBE of a write -> wr_n, cs_n go 1 and data_oe 0 asynchronously; no m0 completion; first post-reset tie goes to port 0.
- Single m0 read addr 0x3, enet_data_in=0xBEEF -> cs_n low 5 cycles, rd_n low cycles 2-4, m0_waitrequest low cycle 5, m0_readdata=0xBEEF.
- Single m1 write addr 0xA data 0x1234 -> enet_addr=0xA, data_out=0x1234, data_oe high for CS window, wr_n low 3 cycles.
- Both ports request continuously for 4 accesses -> grant order 0,1,0,1; each completion isolated to the granted port.
- Read then write, macro on -> one cycle with cs_n=1 and data_oe=0 between HOLD and next SETUP; macro off -> only the IDLE gap.
- SETUP_CYC=2, STROBE_CYC=5, HOLD_CYC=2 -> completion at cycle 9; rd_n low exactly 5 cycles.
